// File: rtl/aes_pkg.sv
// Shared constants, state encoding and GF(2^8) helper for the AES-128 key schedule.
// Used by aes_key_expand; the round-key cache is enabled with AES_KEY_CACHE_EN.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_BYTES  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READY  = 2'b01,
        EXPAND = 2'b10
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Load/advance/read bus of the AES-128 key schedule.
// rk_round exists only when AES_KEY_CACHE_EN is defined.
interface aes_key_expand_if;

    logic       key_we;
    logic [3:0] key_addr;
    logic [7:0] key_byte;
    logic       key_go;
    logic       next_rk;
    logic [3:0] rk_addr;
    logic [7:0] rk_data;
    logic [3:0] round_num;
    logic       busy;
    logic       rk_valid;
`ifdef AES_KEY_CACHE_EN
    logic [3:0] rk_round;
`endif

    modport master (
`ifdef AES_KEY_CACHE_EN
        output rk_round,
`endif
        output key_we, key_addr, key_byte, key_go, next_rk, rk_addr,
        input  rk_data, round_num, busy, rk_valid
    );

    modport slave (
`ifdef AES_KEY_CACHE_EN
        input  rk_round,
`endif
        input  key_we, key_addr, key_byte, key_go, next_rk, rk_addr,
        output rk_data, round_num, busy, rk_valid
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, 256-entry lookup table.
// Entry 0x00 sits in the most significant byte of the table constant.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [7:0] rev_idx;

    always_comb begin
        rev_idx  = 8'hff - in_byte;
        out_byte = SBOX_TBL[{rev_idx, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_key_expand.sv
// Byte-serial AES-128 key schedule: 16-byte key register advanced in place, one byte per cycle.
// AES_KEY_CACHE_EN adds a per-round key cache readable by round index.
//   state  | meaning
//   IDLE   | cipher key being loaded, nothing published
//   READY  | key_reg holds round key round_num
//   EXPAND | producing the next round key, byte b per cycle
module aes_key_expand
    import aes_pkg::*;
(
    input logic             CLK,
    input logic             RST,
    aes_key_expand_if.slave bus
);

    state_e     state_q, state_d;
    logic [7:0] key_q [KEY_BYTES];
    logic [7:0] key_d [KEY_BYTES];
    logic [3:0] round_q, round_d;
    logic [3:0] b_q, b_d;
    logic [7:0] rcon_q, rcon_d;
    logic [7:0] sbox_in, sbox_out;

`ifdef AES_KEY_CACHE_EN
    localparam int CACHE_BYTES = KEY_BYTES * (NUM_ROUNDS + 1);
    logic [7:0] cache_q [CACHE_BYTES];
    logic [7:0] cache_d [CACHE_BYTES];
`endif

    // RotWord folded into the address: byte b of the new column uses row (b+1)%4 of column 3.
    always_comb sbox_in = key_q[{2'b11, b_q[1:0] + 2'd1}];

    aes_sbox u_sbox (
        .in_byte  (sbox_in),
        .out_byte (sbox_out)
    );

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        b_d     = b_q;
        key_d   = key_q;
`ifdef AES_KEY_CACHE_EN
        cache_d = cache_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.key_we) key_d[bus.key_addr] = bus.key_byte;
                if (bus.key_go) begin
                    state_d = READY;
                    round_d = '0;
                    rcon_d  = RCON_INIT;
`ifdef AES_KEY_CACHE_EN
                    for (int i = 0; i < KEY_BYTES; i++) cache_d[i] = key_d[i];
`endif
                end
            end
            READY: begin
                if (bus.key_we) begin
                    key_d[bus.key_addr] = bus.key_byte;
                    round_d = '0;
                    rcon_d  = RCON_INIT;
                    state_d = IDLE;
                end else if (bus.next_rk && (round_q < 4'(NUM_ROUNDS))) begin
                    state_d = EXPAND;
                    b_d     = '0;
                end
            end
            EXPAND: begin
                // Bytes 12..15 are still the previous round while b<4; b-4 is already new for b>=4.
                if (b_q < 4'd4)
                    key_d[b_q] = key_q[b_q] ^ sbox_out ^ ((b_q == 4'd0) ? rcon_q : 8'h00);
                else
                    key_d[b_q] = key_q[b_q] ^ key_q[b_q - 4'd4];
`ifdef AES_KEY_CACHE_EN
                cache_d[{round_q + 4'd1, b_q}] = key_d[b_q];
`endif
                b_d = b_q + 4'd1;
                if (b_q == 4'd15) begin
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            b_q     <= '0;
            for (int i = 0; i < KEY_BYTES; i++) key_q[i] <= '0;
`ifdef AES_KEY_CACHE_EN
            for (int i = 0; i < CACHE_BYTES; i++) cache_q[i] <= '0;
`endif
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            b_q     <= b_d;
            key_q   <= key_d;
`ifdef AES_KEY_CACHE_EN
            cache_q <= cache_d;
`endif
        end
    end

`ifdef AES_KEY_CACHE_EN
    always_comb begin
        bus.rk_data = 8'h00;
        if (bus.rk_round <= round_q) bus.rk_data = cache_q[{bus.rk_round, bus.rk_addr}];
    end
`else
    assign bus.rk_data = key_q[bus.rk_addr];
`endif

    assign bus.round_num = round_q;
    assign bus.busy      = (state_q == EXPAND);
    assign bus.rk_valid  = (state_q == READY);

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus pushes expected round keys, a monitor
// reads the whole key back whenever rk_valid rises or a snapshot is requested.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #50 clk = ~clk;

    aes_key_expand_if bus();

    aes_key_expand dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic         valid;
        logic         busy;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         snap_req = 1'b0;
    logic [7:0] sbox_ref [256];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // ---------------- reference model (FIPS-197 word-oriented key expansion) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] put_byte(input logic [127:0] k, input int a, input logic [7:0] v);
        logic [127:0] r;
        r = k;
        r[127 - 8*a -: 8] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t         e;
        logic [127:0] got;
        logic         prev_v;
        logic         trig;
        logic [3:0]   rn;
        logic         v, b;
        prev_v = 1'b0;
        bus.rk_addr = 4'd0;
`ifdef AES_KEY_CACHE_EN
        bus.rk_round = 4'd0;
`endif
        forever begin
            @(negedge clk);
            trig   = snap_req || (bus.rk_valid === 1'b1 && prev_v !== 1'b1);
            prev_v = bus.rk_valid;
            if (trig) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {127'd0, bus.rk_valid}, 128'd0);
                end else begin
                    e  = exp_q.pop_front();
                    rn = bus.round_num;
                    v  = bus.rk_valid;
                    b  = bus.busy;
                    for (int i = 0; i < 16; i++) begin
                        bus.rk_addr = 4'(i);
`ifdef AES_KEY_CACHE_EN
                        bus.rk_round = e.rnd;
`endif
                        #1;
                        got[127 - 8*i -: 8] = bus.rk_data;
                    end
                    chk("round_num", {124'd0, rn}, {124'd0, e.rnd});
                    chk("rk_valid", {127'd0, v}, {127'd0, e.valid});
                    chk("busy", {127'd0, b}, {127'd0, e.busy});
                    chk("round_key", got, e.key);
                end
                snap_req = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q_empty();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic snap(input logic [127:0] plain, input logic [127:0] cached,
                        input logic [3:0] rnd, input logic v, input logic b);
        exp_t e;
`ifdef AES_KEY_CACHE_EN
        e.key = cached;
`else
        e.key = plain;
`endif
        e.rnd = rnd;
        e.valid = v;
        e.busy = b;
        exp_q.push_back(e);
        snap_req = 1'b1;
        for (int i = 0; i < 20 && snap_req; i++) @(negedge clk);
        #20;
        chk("snapshot_taken", {127'd0, snap_req}, 128'd0);
    endtask

    task automatic load_key(input logic [127:0] k, input bit go_last);
        for (int i = 0; i < 16; i++) begin
            bus.key_we   = 1'b1;
            bus.key_addr = 4'(i);
            bus.key_byte = k[127 - 8*i -: 8];
            if (i == 15 && go_last) begin
                exp_q.push_back('{k, 4'd0, 1'b1, 1'b0});
                bus.key_go = 1'b1;
            end
            tick();
        end
        bus.key_we = 1'b0;
        bus.key_go = 1'b0;
        if (!go_last) begin
            exp_q.push_back('{k, 4'd0, 1'b1, 1'b0});
            bus.key_go = 1'b1;
            tick();
            bus.key_go = 1'b0;
        end
        wait_q_empty();
    endtask

    task automatic step(input bit run, input logic [127:0] k, input logic [3:0] rnd, input bit inject);
        int n;
        if (run) exp_q.push_back('{k, rnd, 1'b1, 1'b0});
        bus.next_rk = 1'b1;
        tick();
        bus.next_rk = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            n++;
            if (inject && n == 3) begin
                bus.key_we   = 1'b1;
                bus.key_addr = 4'd0;
                bus.key_byte = 8'hff;
                bus.key_go   = 1'b1;
            end
            if (inject && n == 4) begin
                bus.key_we = 1'b0;
                bus.key_go = 1'b0;
            end
        end
        chk("busy_cycles", 128'(n), run ? 128'd16 : 128'd0);
        wait_q_empty();
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        logic [127:0] k;
        logic [127:0] cur;
        logic [7:0]   v;
        int           a;
        int           stop_at;
        bus.key_we = 1'b0;
        bus.key_addr = 4'd0;
        bus.key_byte = 8'h00;
        bus.key_go = 1'b0;
        bus.next_rk = 1'b0;
        build_sbox();

        rst = 1'b0;
        tick();
        rst = 1'b1;
        snap(128'd0, 128'd0, 4'd0, 1'b0, 1'b0);

        // FIPS-197 key: full schedule, ignored step at round 10, writes during EXPAND ignored.
        load_key(FIPS_KEY, 1'b0);
        step(1'b1, FIPS_R1, 4'd1, 1'b0);
        step(1'b1, FIPS_R2, 4'd2, 1'b1);
        for (int r = 3; r <= 9; r++) step(1'b1, model_rk(FIPS_KEY, r), 4'(r), 1'b0);
        step(1'b1, FIPS_R10, 4'd10, 1'b0);
        step(1'b0, 128'd0, 4'd0, 1'b0);
        snap(FIPS_R10, FIPS_R10, 4'd10, 1'b1, 1'b0);

        // key_we in READY drops back to IDLE with round 0.
        bus.key_we = 1'b1;
        bus.key_addr = 4'd5;
        bus.key_byte = 8'h5a;
        tick();
        bus.key_we = 1'b0;
        snap(put_byte(FIPS_R10, 5, 8'h5a), FIPS_KEY, 4'd0, 1'b0, 1'b0);

        // Random keys; one is cut short by a simultaneous key_we + next_rk.
        for (int j = 0; j < 3; j++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            stop_at = (j == 1) ? 5 : 10;
            load_key(k, 1'b1);
            for (int r = 1; r <= stop_at; r++) step(1'b1, model_rk(k, r), 4'(r), 1'b0);
            if (j == 1) begin
                cur = model_rk(k, stop_at);
                a = int'($urandom_range(15, 0));
                v = 8'($urandom);
                bus.key_we = 1'b1;
                bus.key_addr = 4'(a);
                bus.key_byte = v;
                bus.next_rk = 1'b1;
                tick();
                bus.key_we = 1'b0;
                bus.next_rk = 1'b0;
                snap(put_byte(cur, a, v), k, 4'd0, 1'b0, 1'b0);
            end
        end

        // Reset in the middle of an expansion.
        load_key(FIPS_KEY, 1'b0);
        bus.next_rk = 1'b1;
        tick();
        bus.next_rk = 1'b0;
        repeat (8) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        snap(128'd0, 128'd0, 4'd0, 1'b0, 1'b0);

        repeat (20) tick();
        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #20000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Byte-serial AES-128 key schedule; sits upstream of data_Mem and feeds round-key bytes to the AddRoundKey step of the round datapath.
- Holds a 16-byte key register that is loaded byte-by-byte, then advanced in place one round at a time (rounds 0..10).
- Uses one shared S-box, so each round takes 16 cycles.
- The consumer reads any byte of the current round key by address.

Parameters:
- NUM_ROUNDS, 10, last round index; round_num saturates at this value.
- KEY_BYTES, 16, key/state size in bytes; fixed for AES-128.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset (sampled on the rising edge of CLK).
- key_we  in  1  write strobe for one cipher-key byte.
- key_addr  in  4  byte address for key_we; byte k = column k/4, row k%4.
- key_byte  in  8  cipher-key data byte.
- key_go  in  1  pulse: key load complete, publish round 0.
- next_rk  in  1  pulse: compute the next round key.
- rk_addr  in  4  read address into the current round key.
- rk_data  out  8  combinational read, key_reg[rk_addr].
- round_num  out  4  index of the round key held (0..10).
- busy  out  1  high during expansion.
- rk_valid  out  1  high when key_reg holds a complete round key.

Behaviour:
- Reset (RST=0 at an edge): state IDLE, key_reg all 00, round_num=0, rcon=01, byte counter=0, busy=0, rk_valid=0.
- States: IDLE, READY, EXPAND.
- IDLE:
  - key_we writes key_byte to key_reg[key_addr].
  - key_go moves to READY; rk_valid=1, round_num=0.
- READY:
  - key_we writes the byte, sets round_num=0, rcon=01, rk_valid=0, and returns to IDLE.
  - next_rk with round_num<NUM_ROUNDS moves to EXPAND; busy=1 and rk_valid=0 from the next cycle.
  - next_rk with round_num==NUM_ROUNDS is ignored; the block stays in READY.
- EXPAND: a 4-bit counter b runs 0..15, one byte per cycle, updated in place.
  - b<4: key_reg[b] ^= Sbox(key_reg[12+((b+1)%4)]) ^ (b==0 ? rcon : 00).
  - b>=4: key_reg[b] ^= key_reg[b-4].
  - Bytes 12..15 are still old while b<4, and key_reg[b-4] is already new when b>=4. This ordering is mandatory.
- End of EXPAND: on the edge that writes b=15, round_num increments, rcon=xtime(rcon) (01,02,..,80,1B,36), and the next state is READY.
  - busy=0 and rk_valid=1 from the following cycle.
  - Latency from next_rk sampled to rk_valid=1 is 17 cycles.
- key_we, key_go and next_rk are ignored in EXPAND.
- Simultaneous key_we and key_go in IDLE: the byte is written and the state goes to READY; the published key includes the new byte.
- Simultaneous key_we and next_rk in READY: the write wins and next_rk is dropped.
- rk_data always reflects key_reg. During EXPAND it may be partially updated; consumers qualify it with rk_valid.
- Reset mid-EXPAND: the key is lost and the block returns to the reset state.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- Defined:
  - Every published round key (rounds 0..10) is also copied into a 176-byte cache, 16 bytes per round, written during EXPAND and at key_go.
  - An extra input rk_round[3:0] is added. rk_data = cache[rk_round*16+rk_addr] when rk_round<=round_num; otherwise rk_data=00.
  - This lets a decrypt pass read keys in reverse order without reloading.
- Undefined: no cache and no rk_round port; rk_data reads only the current round key.

Decomposition:
- Package aes_pkg holds:
  - NUM_ROUNDS and KEY_BYTES constants.
  - State encoding IDLE=2'b00, READY=2'b01, EXPAND=2'b10.
  - RCON_INIT=8'h01.
  - An xtime function for the rcon update.
- One sub-module: aes_sbox (8-bit in, 8-bit out, combinational 256-entry table), shared with the data_Mem sbox path.

Test Plan:
- Reset with RST=0 for one edge → rk_valid=0, busy=0, round_num=0, rk_data=00 for all addresses.
- Load key 2b7e151628aed2a6abf7158809cf4f3c (addr0=2b), pulse key_go → rk_valid=1, round_num=0, rk_data@0=2b, @15=3c.
- Pulse next_rk → busy=1 for exactly 16 cycles, then round_num=1 and key reads a0fafe1788542cb123a339392a6c7605.
- Pulse next_rk 9 more times → round_num=10, key d014f9a8c9ee2589e13f0cc8b6630ca6. A further next_rk leaves busy=0 and the key unchanged.
- Pulse key_we and key_go during EXPAND → both ignored, and the round 2 key matches f2c295f27a96b9435935807a7359f67f. Then key_we in READY → rk_valid=0, round_num=0.
- Drive RST=0 at cycle 8 of EXPAND → next cycle has all outputs at reset values and key_reg is all 00.
